// File: rtl/yutorina_rst_ctrl_pkg.sv
// Shared definitions for the yutorina reset sequencer.
// Holds the FSM state encodings, the counter limit and a saturating increment.
package yutorina_rst_ctrl_pkg;

   typedef enum logic [1:0] {
      RST_ST_WAIT_LOCK = 2'd0,
      RST_ST_HOLD      = 2'd1,
      RST_ST_RUN       = 2'd2
   } rst_state_t;

   localparam logic [7:0] RST_CNT_MAX = 8'd255;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == RST_CNT_MAX) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/yutorina_sync_debounce.sv
// Multi-flop synchroniser followed by a counter-based level debouncer.
// Ports: clk, rst_ (sync, active-low), in (async level), out (debounced level).
module yutorina_sync_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_WIDTH       = 16
) (
   input  logic clk,
   input  logic rst_,
   input  logic in,
   output logic out
);

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_WIDTH-1:0]   cnt_q;
   logic                   s;

   assign s = sync_q[SYNC_STAGES-1];

   // The counter only runs while the synchronised sample disagrees with
   // the debounced level; any agreeing sample restarts the count.
   always_ff @(posedge clk) begin
      if (!rst_) begin
         sync_q <= '0;
         cnt_q  <= '0;
         out    <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], in};
         if (s == out) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            out   <= s;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/yutorina_rst_ctrl.sv
// Reset sequencer: debounced switch + clock lock gate a timed chip reset.
// Ports: clk, rst_ (sync, active-low), rst_sw, locked (async inputs),
//        chip_rst (registered), rst_done (release pulse), rst_cnt (saturating).
module yutorina_rst_ctrl
   import yutorina_rst_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int HOLD_CYCLES     = 8,
   parameter int CNT_WIDTH       = 16
) (
   input  logic       clk,
   input  logic       rst_,
   input  logic       rst_sw,
   input  logic       locked,
   output logic       chip_rst,
   output logic       rst_done,
   output logic [7:0] rst_cnt
);

   localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);

   logic                 deb;
   logic                 lock_s;
   logic                 abort;
   rst_state_t           state_q;
   rst_state_t           state_d;
   logic [CNT_WIDTH-1:0] hold_q;
   logic [CNT_WIDTH-1:0] hold_d;
   logic                 chip_d;
   logic                 done_d;
   logic [7:0]           cnt_d;

   yutorina_sync_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_WIDTH       (CNT_WIDTH)
   ) u_sw (
      .clk  (clk),
      .rst_ (rst_),
      .in   (rst_sw),
      .out  (deb)
   );

   // Lock only needs synchronising; a single-sample debounce adds one flop.
   yutorina_sync_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (1),
      .CNT_WIDTH       (CNT_WIDTH)
   ) u_lock (
      .clk  (clk),
      .rst_ (rst_),
      .in   (locked),
      .out  (lock_s)
   );

   assign abort = !lock_s || deb;

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      done_d  = 1'b0;
      cnt_d   = rst_cnt;
      case (state_q)
         RST_ST_WAIT_LOCK: begin
            if (!abort) begin
               state_d = RST_ST_HOLD;
               hold_d  = '0;
            end
         end
         RST_ST_HOLD: begin
            // Abort is checked first so it beats completion on the same edge.
            if (abort) begin
               state_d = RST_ST_WAIT_LOCK;
            end else if (hold_q == HOLD_LAST) begin
               state_d = RST_ST_RUN;
               done_d  = 1'b1;
               cnt_d   = sat_inc(rst_cnt);
            end else begin
               hold_d = hold_q + CNT_WIDTH'(1);
            end
         end
         RST_ST_RUN: begin
            if (abort) begin
               state_d = RST_ST_WAIT_LOCK;
            end
         end
         default: begin
            state_d = RST_ST_WAIT_LOCK;
         end
      endcase
      chip_d = (state_d != RST_ST_RUN);
   end

   always_ff @(posedge clk) begin
      if (!rst_) begin
         state_q  <= RST_ST_WAIT_LOCK;
         hold_q   <= '0;
         chip_rst <= 1'b1;
         rst_done <= 1'b0;
         rst_cnt  <= 8'd0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         chip_rst <= chip_d;
         rst_done <= done_d;
         rst_cnt  <= cnt_d;
      end
   end

endmodule
